// File: rtl/execution_muldiv_if.sv
// execution_muldiv_if: EX-stage <-> mul/div unit bundle.
//   i_valid/i_op/i_data_rs/i_data_rt : mul/div-class instruction and its forwarded operands
//   i_read_hilo                      : EX holds MFHI/MFLO this cycle
//   i_flush                          : EX instruction is squashed
//   o_hi/o_lo                        : architectural HI/LO registers
//   o_busy/o_stall/o_done            : in-flight, hazard stall, HI/LO-written pulse
interface execution_muldiv_if #(
  parameter int PROC_BITS = 32
);
  logic                 i_valid;
  logic [2:0]           i_op;
  logic [PROC_BITS-1:0] i_data_rs;
  logic [PROC_BITS-1:0] i_data_rt;
  logic                 i_read_hilo;
  logic                 i_flush;
  logic [PROC_BITS-1:0] o_hi;
  logic [PROC_BITS-1:0] o_lo;
  logic                 o_busy;
  logic                 o_stall;
  logic                 o_done;

  modport master (
    output i_valid, i_op, i_data_rs, i_data_rt, i_read_hilo, i_flush,
    input  o_hi, o_lo, o_busy, o_stall, o_done
  );

  modport slave (
    input  i_valid, i_op, i_data_rs, i_data_rt, i_read_hilo, i_flush,
    output o_hi, o_lo, o_busy, o_stall, o_done
  );
endinterface

// File: rtl/execution_muldiv.sv
// execution_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-low reset
//   bus     : execution_muldiv_if slave (request, operands, HI/LO, busy/stall/done)
// Operands are reduced to magnitudes at accept, PROC_BITS iterations run on
// unsigned magnitudes, and one FIX cycle applies sign correction and writes HI/LO.
module execution_muldiv #(
  parameter int PROC_BITS = 32,
  parameter int CNT_BITS  = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  execution_muldiv_if.slave    bus
);
  localparam int N = PROC_BITS;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [N-1:0]        acc_hi_q, acc_lo_q, opb_q;
  logic                is_div_q, neg_lo_q, neg_hi_q;
  logic [N-1:0]        hi_q, lo_q;
  logic                busy_q, done_q;

  // accept / operand decode
  op_e          op;
  logic         op_real, accept, start, is_signed, a_neg, b_neg, op_div;
  logic [N-1:0] a_mag, b_mag;

  assign op        = op_e'(bus.i_op);
  assign op_real   = (op != OP_NONE) && (op != OP_RSVD);
  assign accept    = bus.i_valid && !bus.i_flush && !busy_q && op_real;
  assign start     = accept && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed && bus.i_data_rs[N-1];
  assign b_neg     = is_signed && bus.i_data_rt[N-1];
  // MIN_NEG negates to itself, which read as unsigned is the exact magnitude
  assign a_mag     = a_neg ? -bus.i_data_rs : bus.i_data_rs;
  assign b_mag     = b_neg ? -bus.i_data_rt : bus.i_data_rt;

  // one multiply step: conditional add into the high half, then shift {sum,lo} right
  logic [N:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

  // one restoring-divide step: shift next dividend bit into the partial remainder
  logic [N:0]   div_sh;
  logic         div_ge;
  logic [N-1:0] div_rem;
  assign div_sh  = {acc_hi_q, acc_lo_q[N-1]};
  assign div_ge  = div_sh >= {1'b0, opb_q};
  // when div_ge the difference is below the divisor, so N bits suffice
  assign div_rem = div_ge ? (div_sh[N-1:0] - opb_q) : div_sh[N-1:0];

  // sign correction applied in FIX
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   hi_fix, lo_fix;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;
  always_comb begin
    hi_fix = prod_fix[2*N-1:N];
    lo_fix = prod_fix[N-1:0];
    if (is_div_q) begin
      hi_fix = neg_hi_q ? -acc_hi_q : acc_hi_q;
      lo_fix = neg_lo_q ? -acc_lo_q : acc_lo_q;
    end
  end

  // FSM
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_BITS'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          if (op == OP_MTHI)      hi_q <= bus.i_data_rs;
          else if (op == OP_MTLO) lo_q <= bus.i_data_rs;
          else begin
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            opb_q    <= b_mag;
            is_div_q <= op_div;
            // divide-by-zero keeps the all-ones quotient unsigned
            neg_lo_q <= (a_neg ^ b_neg) && !(op_div && bus.i_data_rt == '0);
            neg_hi_q <= a_neg;
            cnt_q    <= CNT_BITS'(N);
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CNT_BITS'(1);
          if (is_div_q) begin
            acc_hi_q <= div_rem;
            acc_lo_q <= {acc_lo_q[N-2:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[N:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[N-1:1]};
          end
        end
        S_FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_hi    = hi_q;
  assign bus.o_lo    = lo_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  // flush does not gate the stall: a squashed younger op still waits, then is dropped
  assign bus.o_stall = busy_q && ((bus.i_valid && op_real) || bus.i_read_hilo);
endmodule

// File: tb/tb_execution_muldiv.sv
module tb_execution_muldiv;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execution_muldiv_if #(.PROC_BITS(N)) b();
  execution_muldiv_if #(.PROC_BITS(8)) b8();

  execution_muldiv #(.PROC_BITS(N), .CNT_BITS(6)) dut (.i_clock(clk), .i_reset(rst), .bus(b));
  execution_muldiv #(.PROC_BITS(8), .CNT_BITS(4)) dut8 (.i_clock(clk), .i_reset(rst), .bus(b8));

  typedef struct { logic [N-1:0] hi; logic [N-1:0] lo; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    longint sa, sd, q, r;
    logic [63:0] ua, ud;
    sa = longint'($signed(a));
    sd = longint'($signed(d));
    ua = {32'b0, a};
    ud = {32'b0, d};
    case (op)
      3'd1: return 64'(sa * sd);
      3'd2: return ua * ud;
      3'd3: begin
        if (d == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sd; r = sa % sd;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (d == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ud), 32'(ua / ud)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] m;
    exp_t e;
    m = model(op, a, d);
    e.hi = m[63:32];
    e.lo = m[31:0];
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    b.i_valid = 1'b1; b.i_op = op; b.i_data_rs = a; b.i_data_rt = d;
    if (op >= 3'd1 && op <= 3'd4) push(op, a, d);
    cyc();
    b.i_valid = 1'b0; b.i_op = 3'd0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      cyc();
    end
    if (!ok) begin
      chk("timeout", 64'd0, 64'd1);
      sb.delete();
    end
    cyc();
  endtask

  // output monitor: pops the scoreboard on each done pulse
  int busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (b.o_busy) busy_cnt++;
      if (b.o_done) begin
        chk("done_once", 64'(prev_done), 64'd0);
        chk("busy_len", 64'(busy_cnt), 64'(N + 1));
        busy_cnt = 0;
        if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("hi", 64'(b.o_hi), 64'(e.hi));
          chk("lo", 64'(b.o_lo), 64'(e.lo));
        end
      end
      prev_done = b.o_done;
    end
  end

  initial begin
    int cnt8;
    logic [2:0] rop;
    logic [31:0] ra, rd;
    b.i_valid = 0; b.i_op = 0; b.i_data_rs = 0; b.i_data_rt = 0; b.i_read_hilo = 0; b.i_flush = 0;
    b8.i_valid = 0; b8.i_op = 0; b8.i_data_rs = 0; b8.i_data_rt = 0; b8.i_read_hilo = 0; b8.i_flush = 0;
    cyc(); cyc();
    chk("rst_hi", 64'(b.o_hi), 64'd0);
    chk("rst_lo", 64'(b.o_lo), 64'd0);
    chk("rst_busy", 64'(b.o_busy), 64'd0);
    chk("rst_done", 64'(b.o_done), 64'd0);
    rst = 1'b1;
    cyc();

    // MTHI / MTLO
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi", 64'(b.o_hi), 64'h1234_5678);
    chk("mthi_busy", 64'(b.o_busy), 64'd0);
    issue(3'd6, 32'hCAFE_BABE, 32'd0);
    chk("mtlo", 64'(b.o_lo), 64'hCAFE_BABE);
    chk("mtlo_hi", 64'(b.o_hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(b.o_busy), 64'd0);

    // directed mul/div
    issue(3'd1, 32'hFFFF_FFFE, 32'd7);      wait_idle();
    issue(3'd2, 32'hFFFF_FFFE, 32'd7);      wait_idle();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);      wait_idle();
    issue(3'd4, 32'd100, 32'd7);            wait_idle();
    issue(3'd3, 32'd5, 32'd0);              wait_idle();
    issue(3'd3, 32'hFFFF_FFFB, 32'd0);      wait_idle();
    issue(3'd4, 32'hFFFF_FFFB, 32'd0);      wait_idle();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000); wait_idle();
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);      wait_idle();

    // random mul/div
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rd  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(rop, ra, rd);
      wait_idle();
    end

    // stall window and held MULT accepted only once the DIV completes
    issue(3'd3, 32'd1000, 32'd3);
    for (int k = 1; k <= N + 2; k++) begin
      cyc();
      b.i_read_hilo = (k >= 3 && k <= N + 1);
      b.i_valid     = (k >= 5 && k <= N + 1);
      b.i_op        = 3'd1;
      b.i_data_rs   = 32'd12345;
      b.i_data_rt   = 32'hFFFF_FF00;
      if (k == 5) push(3'd1, 32'd12345, 32'hFFFF_FF00);
      @(negedge clk);
      chk($sformatf("stall_k%0d", k), 64'(b.o_stall), 64'(k >= 3 && k <= N));
      chk($sformatf("busy_k%0d", k), 64'(b.o_busy), 64'(k <= N || k == N + 2));
      if (k == N + 1) chk("done_k", 64'(b.o_done), 64'd1);
    end
    b.i_valid = 0; b.i_op = 0; b.i_read_hilo = 0;
    wait_idle();

    // stall decode while busy: NONE / reserved do not stall, flushed op does
    issue(3'd2, 32'hDEAD_BEEF, 32'h1357_9BDF);
    b.i_valid = 1; b.i_op = 3'd0;
    @(negedge clk); chk("stall_none", 64'(b.o_stall), 64'd0);
    b.i_op = 3'd7;
    #1; chk("stall_rsvd", 64'(b.o_stall), 64'd0);
    b.i_op = 3'd3; b.i_flush = 1;
    #1; chk("stall_flush", 64'(b.o_stall), 64'd1);
    b.i_valid = 0; b.i_op = 0; b.i_flush = 0;
    wait_idle();

    // flushed DIV while idle is dropped
    b.i_valid = 1; b.i_op = 3'd3; b.i_data_rs = 32'd9; b.i_data_rt = 32'd2; b.i_flush = 1;
    cyc();
    b.i_valid = 0; b.i_op = 0; b.i_flush = 0;
    chk("flush_busy", 64'(b.o_busy), 64'd0);
    cyc(); cyc();
    chk("flush_busy2", 64'(b.o_busy), 64'd0);

    // async reset mid-MULT
    issue(3'd5, 32'h0000_0055, 32'd0);
    issue(3'd1, 32'd77, 32'd99);
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(b.o_busy), 64'd0);
    chk("arst_hi", 64'(b.o_hi), 64'd0);
    chk("arst_lo", 64'(b.o_lo), 64'd0);
    sb.delete();
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // 8-bit instance: 0x80 * 0x80 signed
    b8.i_valid = 1; b8.i_op = 3'd1; b8.i_data_rs = 8'h80; b8.i_data_rt = 8'h80;
    cyc();
    b8.i_valid = 0; b8.i_op = 0;
    cnt8 = 0;
    for (int k = 0; k < 40; k++) begin
      if (b8.o_done) break;
      if (b8.o_busy) cnt8++;
      cyc();
    end
    chk("p8_done", 64'(b8.o_done), 64'd1);
    chk("p8_busy", 64'(cnt8), 64'd9);
    chk("p8_prod", 64'({b8.o_hi, b8.o_lo}), 64'h4000);

    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/execution_muldiv.md
Name: execution_muldiv

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers. It is instantiated beside the single-cycle ALU in the Execution stage. It takes forwarding-resolved rs/rt operands and runs MULT/MULTU/DIV/DIVU iteratively over PROC_BITS cycles. While an operation is in flight it raises a stall to the hazard logic whenever a younger instruction needs the unit or HI/LO.

Parameters:
PROC_BITS, 32, operand/HI/LO width (≥4, even)
CNT_BITS, 6, iteration counter width; must satisfy 2**CNT_BITS > PROC_BITS

Ports:
i_clock  in  1  rising-edge clock
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  EX holds a mul/div-class instruction this cycle
i_op  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (=NONE)
i_data_rs  in  PROC_BITS  forwarded rs operand (multiplicand/dividend/MTxx source)
i_data_rt  in  PROC_BITS  forwarded rt operand (multiplier/divisor)
i_read_hilo  in  1  EX holds MFHI/MFLO this cycle
i_flush  in  1  EX instruction is squashed; do not accept it
o_hi  out  PROC_BITS  HI register
o_lo  out  PROC_BITS  LO register
o_busy  out  1  operation in flight
o_stall  out  1  freeze IF/ID/EX, bubble into MEM
o_done  out  1  one-cycle pulse when HI/LO were written by MULT/DIV

Behaviour:
- Reset (i_reset low, async): state IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0; counter and datapath registers 0. Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- Accept condition: i_valid & !i_flush & !o_busy & op∈{MULT..MTLO}. Any op arriving while o_busy, or with i_flush high, is ignored (no state change).
- MTHI/MTLO: single cycle. HI (or LO) ← i_data_rs at the accept edge; o_done is not pulsed; state stays IDLE.
- FSM:
  - IDLE → RUN on accepting MULT/MULTU/DIV/DIVU. At this edge: latch operand magnitudes (absolute values for signed ops), latch the result-sign flags and the op, counter ← PROC_BITS, o_busy ← 1.
  - RUN: one iteration per edge, counter ← counter−1; go to FIX when counter==1 at the edge.
  - FIX: one edge. Apply sign correction, write HI/LO, o_busy ← 0, o_done ← 1 for one cycle, go to IDLE.
- Latency: accept at edge E0; HI/LO valid after edge E(PROC_BITS+1); o_busy high for exactly PROC_BITS+1 cycles (33 at default). A new op may be accepted in the cycle o_done is high.
- Multiply: shift-add over 2*PROC_BITS-bit product. {HI,LO} = full product. Signed form is negated in FIX if operand signs differ.
- Divide: restoring shift-subtract, one quotient bit per iteration.
  - LO = quotient, truncated toward zero. HI = remainder, carrying the sign of the dividend.
  - Divisor 0: HI=dividend, LO=all ones. Defined behaviour, no trap.
  - DIV of MIN_NEG by −1: LO=MIN_NEG, HI=0.
- Signed magnitude of MIN_NEG is represented in PROC_BITS unsigned without loss.
- o_stall (combinational) = o_busy & ((i_valid & i_op≠NONE) | i_read_hilo). i_flush does not gate it: a squashed younger op still waits and is then dropped.
- o_hi/o_lo are register outputs. The EX mux selects them for MFHI/MFLO. No HI/LO bypass: MFHI issued the cycle after MTHI sees the new value, since the register is updated at the accept edge.
- Unrelated instructions (i_valid=0, i_read_hilo=0) flow while o_busy; the unit runs in the background.

Test Plan:
- Reset and MTxx: MTHI 0x12345678, then MTLO 0xCAFEBABE → o_hi=0x12345678 and o_lo=0xCAFEBABE one edge after each; o_busy stays 0.
- MULT signed: rs=0xFFFFFFFE (−2), rt=7 → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFF2; o_done pulses once. MULTU with the same operands → HI=0x00000006, LO=0xFFFFFFF2.
- DIV signed: rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2. Divisor 0, rs=5 → HI=5, LO=0xFFFFFFFF.
- Stall: MFLO asserted 3 cycles after DIV accept → o_stall high until the o_done cycle, low in that cycle. A second MULT presented while busy is not accepted until o_done.
- Flush/reset: DIV with i_flush=1 → not accepted, o_busy stays 0. i_reset pulsed low at cycle 10 of a MULT → o_busy=0 and HI=LO=0 immediately, before the next clock edge.
- Parametrisation: PROC_BITS=8, MULT 0x80×0x80 → {HI,LO}=0x4000; busy for 9 cycles.
